// File: rtl/stack_arb.sv
// stack_arb: arbitrates two REQ/ACK ports onto one shared stack instance.
// Define STACK_ARB_FIXED_PRI_EN for fixed priority (port 0 wins every tie).
module stack_arb #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  OP0,
  input  logic                  OP1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [CW-1:0]         COUNT,
  output logic                  STK_PUSH,
  output logic                  STK_POP,
  output logic [DATA_WIDTH-1:0] STK_DATA_IN,
  input  logic [DATA_WIDTH-1:0] STK_DATA_OUT,
  input  logic                  STK_FULL,
  input  logic                  STK_EMPTY
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]            state;
  logic                  gnt;
  logic                  gnt_op;
  logic                  win;
  logic                  win_op;
  logic [DATA_WIDTH-1:0] win_wd;
  logic                  reject;

`ifdef STACK_ARB_FIXED_PRI_EN
  assign win = ~REQ0;
`else
  logic last;
  // on a tie the port not served last goes first
  assign win = (REQ0 & REQ1) ? ~last : REQ1;
`endif

  assign win_op = win ? OP1 : OP0;
  assign win_wd = win ? WDATA1 : WDATA0;
  assign reject = win_op ? STK_FULL : STK_EMPTY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      gnt_op      <= 1'b0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= '0;
      COUNT       <= '0;
      STK_PUSH    <= 1'b0;
      STK_POP     <= 1'b0;
      STK_DATA_IN <= '0;
`ifndef STACK_ARB_FIXED_PRI_EN
      last        <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ0 | REQ1) begin
            gnt    <= win;
            gnt_op <= win_op;
`ifndef STACK_ARB_FIXED_PRI_EN
            last   <= win;
`endif
            if (reject) begin
              ERR   <= 1'b1;
              RDATA <= '0;
              ACK0  <= ~win;
              ACK1  <= win;
              state <= RESP;
            end else begin
              STK_PUSH    <= win_op;
              STK_POP     <= ~win_op;
              STK_DATA_IN <= win_wd;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          STK_PUSH <= 1'b0;
          STK_POP  <= 1'b0;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          RDATA <= STK_DATA_OUT;
          if (gnt_op) begin
            if (COUNT != CW'(DEPTH)) COUNT <= COUNT + CW'(1);
          end else begin
            if (COUNT != '0) COUNT <= COUNT - CW'(1);
          end
          ACK0  <= ~gnt;
          ACK1  <= gnt;
          state <= RESP;
        end
        RESP: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          ERR   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
